add_seq32: RTL

ADD_SEQ32 -- requirements
Module: add_seq32

---
 rtl/add_seq32.sv | 123 ++++++++++++
 1 files changed

// File: rtl/add_seq32.sv
// Byte-serial add/subtract unit. One 8-bit adder is reused LSB-first across
// the operand bytes, with the carry held in a register between bytes.
// The result, carry and overflow are loaded only at the end of an operation.

// 8-bit adder slice with carry in and carry out.
module adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {8'd0, ci};

endmodule

module add_seq32 #(
  parameter int NBYTES = 4
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iStart,
  input  logic                  iSub,
  input  logic [8*NBYTES-1:0]   iData_a,
  input  logic [8*NBYTES-1:0]   iData_b,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [8*NBYTES-1:0]   oData,
  output logic                  oData_C,
  output logic                  oOverflow
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [NBYTES-1:0][7:0]  a_reg;
  logic [NBYTES-1:0][7:0]  b_reg;
  logic [W-9:0]            res_sh;
  logic [IDX_W-1:0]        idx;
  logic                    carry;
  logic [7:0]              sum_byte;
  logic                    carry_out;

  // Status outputs decode straight from the state register.
  assign oBusy = (state != IDLE);
  assign oDone = (state == DONE);

  // The single shared adder sees the current byte of each operand.
  adder8 u_adder (
    .a  (a_reg[idx]),
    .b  (b_reg[idx]),
    .ci (carry),
    .s  (sum_byte),
    .co (carry_out)
  );

  // State register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: IDLE waits for a start, RUN walks the bytes, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iStart) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, byte-serial accumulation and end-of-operation result load.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_sh    <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      oData     <= '0;
      oData_C   <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            a_reg <= iData_a;
            b_reg <= iSub ? ~iData_b : iData_b;
            carry <= iSub;
            idx   <= '0;
          end
        end
        RUN: begin
          // Partial result fills from the top so it is aligned after the last byte.
          res_sh <= (W-8)'({sum_byte, res_sh} >> 8);
          carry  <= carry_out;
          idx    <= idx + IDX_W'(1);
          if (idx == LAST) begin
            oData     <= {sum_byte, res_sh};
            oData_C   <= carry_out;
            oOverflow <= (a_reg[NBYTES-1][7] == b_reg[NBYTES-1][7]) &&
                         (sum_byte[7] != a_reg[NBYTES-1][7]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
